// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: PC width, FSM encodings and
// the default reset/fault vector.
package cpu_pkg;

  localparam int PC_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10,
    ST_RSVD  = 2'b11
  } state_t;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push writes at the count, pop reads the entry below it.
// Contents are not reset; only the occupancy count is.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clkin,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty && !push;
  assign w_wr_idx  = AW'(r_count);
  assign w_rd_idx  = AW'(r_count - CW'(1));
  assign top       = r_mem[w_rd_idx];

  always_ff @(posedge clkin) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with a RUN/HALT/FAULT control FSM and a call/return stack.
// pc_next is combinational; the external pc register closes the loop.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic            clkin,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  output logic [PC_W-1:0] pc_next,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            br_en,
  input  logic            br_cond,
  input  logic [PC_W-1:0] br_off,
  input  logic            jmp_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] jmp_addr,
  output logic [1:0]      state,
  output logic            stk_full,
  output logic            stk_empty,
  output logic            err
);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_err;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_br;
  logic [PC_W-1:0] w_top;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_fault;

  // 8-bit wrap of the sum is exactly sign-extended offset addition mod 256
  assign w_pc_inc = pc_cur + PC_W'(1);
  assign w_pc_br  = pc_cur + br_off;

  ret_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clkin    (clkin),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .push_data(w_pc_inc),
    .top      (w_top),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clkin) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_fault) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_pc_next    = pc_cur;
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_fault      = 1'b0;
    if (!reset) begin
      w_pc_next = RESET_PC;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt) begin
            w_state_next = ST_HALT;
          end else if (!stall) begin
            // ret outranks call, so a simultaneous call is simply dropped
            if (ret_en) begin
              if (w_empty) begin
                w_fault = 1'b1;
              end else begin
                w_pop     = 1'b1;
                w_pc_next = w_top;
              end
            end else if (call_en) begin
              if (w_full) begin
                w_fault = 1'b1;
              end else begin
                w_push    = 1'b1;
                w_pc_next = jmp_addr;
              end
            end else if (jmp_en) begin
              w_pc_next = jmp_addr;
            end else if (br_en && br_cond) begin
              w_pc_next = w_pc_br;
            end else begin
              w_pc_next = w_pc_inc;
            end
            if (w_fault) begin
              w_pc_next    = RESET_PC;
              w_state_next = ST_FAULT;
            end
          end
        end
        ST_HALT: begin
          if (resume) begin
            w_state_next = ST_RUN;
          end
        end
        default: begin
          w_state_next = ST_FAULT;
        end
      endcase
    end
  end

  assign pc_next   = w_pc_next;
  assign state     = r_state;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign err       = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;

  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h00;

  logic       clkin = 1'b0;
  logic       reset;
  logic [7:0] pc_cur;
  logic [7:0] pc_next;
  logic       stall, halt, resume, br_en, br_cond, jmp_en, call_en, ret_en;
  logic [7:0] br_off, jmp_addr;
  logic [1:0] state;
  logic       stk_full, stk_empty, err;

  always #5 clkin = ~clkin;

  pc_sequencer #(
    .STACK_DEPTH(DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .pc_cur   (pc_cur),
    .pc_next  (pc_next),
    .stall    (stall),
    .halt     (halt),
    .resume   (resume),
    .br_en    (br_en),
    .br_cond  (br_cond),
    .br_off   (br_off),
    .jmp_en   (jmp_en),
    .call_en  (call_en),
    .ret_en   (ret_en),
    .jmp_addr (jmp_addr),
    .state    (state),
    .stk_full (stk_full),
    .stk_empty(stk_empty),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0=RUN, 1=HALT, 2=FAULT; stack as a queue, back is top
  logic [7:0] m_stk[$];
  int         m_mode = 0;
  bit         m_err  = 1'b0;
  logic [7:0] m_last_pc = 8'h00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    stall = 0; halt = 0; resume = 0; br_en = 0; br_cond = 0; br_off = 8'h00;
    jmp_en = 0; call_en = 0; ret_en = 0; jmp_addr = 8'h00;
  endtask

  // Called just after a falling edge with inputs applied; checks, then
  // clocks once and advances the model. lit_pc >= 0 adds a literal check.
  task automatic cycle(input string tag, input int lit_pc);
    logic [7:0] e_pc;
    int         n_mode;
    bit         do_push, do_pop, fault;
    int         off;
    #1;
    e_pc = pc_cur; n_mode = m_mode; do_push = 0; do_pop = 0; fault = 0;
    if (!reset) begin
      e_pc = RPC;
    end else if (m_mode == 0) begin
      if (halt) n_mode = 1;
      else if (!stall) begin
        if (ret_en) begin
          if (m_stk.size() == 0) fault = 1;
          else begin do_pop = 1; e_pc = m_stk[$]; end
        end else if (call_en) begin
          if (m_stk.size() == DEPTH) fault = 1;
          else begin do_push = 1; e_pc = jmp_addr; end
        end else if (jmp_en) e_pc = jmp_addr;
        else if (br_en && br_cond) begin
          off  = (int'(br_off) > 127) ? int'(br_off) - 256 : int'(br_off);
          e_pc = 8'((int'(pc_cur) + off + 256) % 256);
        end else e_pc = 8'((int'(pc_cur) + 1) % 256);
        if (fault) begin e_pc = RPC; n_mode = 2; end
      end
    end else if (m_mode == 1) begin
      if (resume) n_mode = 0;
    end
    check({tag, ".pc_next"}, pc_next, e_pc);
    check({tag, ".state"}, {6'b0, state}, 8'(m_mode));
    check({tag, ".stk_full"}, {7'b0, stk_full}, {7'b0, m_stk.size() == DEPTH});
    check({tag, ".stk_empty"}, {7'b0, stk_empty}, {7'b0, m_stk.size() == 0});
    check({tag, ".err"}, {7'b0, err}, {7'b0, m_err});
    if (lit_pc >= 0) check({tag, ".pc_lit"}, pc_next, 8'(lit_pc));
    $display("cycle %s: pc_cur=%h pc_next=%h state=%0d", tag, pc_cur, pc_next, state);
    @(posedge clkin);
    if (!reset) begin
      m_stk.delete(); m_mode = 0; m_err = 0;
    end else begin
      if (do_push) m_stk.push_back(8'((int'(pc_cur) + 1) % 256));
      if (do_pop) void'(m_stk.pop_back());
      if (fault) m_err = 1;
      m_mode = n_mode;
    end
    m_last_pc = e_pc;
    @(negedge clkin);
  endtask

  logic [7:0] call_pcs [4];

  initial begin
    call_pcs[0] = 8'h20; call_pcs[1] = 8'h30; call_pcs[2] = 8'h40; call_pcs[3] = 8'h50;
    set_idle();
    reset  = 0;
    pc_cur = 8'h37;
    @(negedge clkin);
    // reset overrides any request
    call_en = 1; jmp_en = 1; jmp_addr = 8'hAA;
    cycle("rst0", int'(RPC));
    cycle("rst1", int'(RPC));
    set_idle();
    reset = 1;
    check("rst_state", {6'b0, state}, 8'h00);
    check("rst_empty", {7'b0, stk_empty}, 8'h01);
    check("rst_err", {7'b0, err}, 8'h00);

    pc_cur = 8'h00; cycle("inc00", 8'h01);
    pc_cur = 8'hFF; cycle("incFF", 8'h00);
    pc_cur = 8'h10; br_en = 1; br_cond = 1; br_off = 8'hFC; cycle("br_taken", 8'h0C);
    br_cond = 0; cycle("br_not", 8'h11);
    set_idle();

    call_en = 1; jmp_addr = 8'h80;
    for (int i = 0; i < 4; i++) begin pc_cur = call_pcs[i]; cycle("call", 8'h80); end
    check("full_after_calls", {7'b0, stk_full}, 8'h01);
    call_en = 0; ret_en = 1; pc_cur = 8'h80;
    for (int i = 3; i >= 0; i--) cycle("ret", int'(call_pcs[i]) + 1);
    check("empty_after_rets", {7'b0, stk_empty}, 8'h01);
    set_idle();

    call_en = 1; jmp_addr = 8'h80;
    for (int i = 0; i < 4; i++) begin pc_cur = call_pcs[i]; cycle("refill", 8'h80); end
    pc_cur = 8'h60; cycle("overflow", 8'h00);
    check("ovf_err", {7'b0, err}, 8'h01);
    check("ovf_state", {6'b0, state}, 8'h02);
    call_en = 0; resume = 1; cycle("fault_resume", 8'h60);
    check("fault_stays", {6'b0, state}, 8'h02);
    set_idle();

    reset = 0; cycle("rst_fault", int'(RPC)); reset = 1;
    pc_cur = 8'h05; halt = 1; jmp_en = 1; jmp_addr = 8'h99; cycle("halt_jmp", 8'h05);
    check("halted", {6'b0, state}, 8'h01);
    halt = 0; jmp_en = 0; resume = 1; cycle("resume", 8'h05);
    check("resumed", {6'b0, state}, 8'h00);
    resume = 0; jmp_en = 1; cycle("jmp_after", 8'h99);
    set_idle();

    call_en = 1; jmp_addr = 8'h70;
    pc_cur = 8'h60; cycle("c1", 8'h70);
    pc_cur = 8'h61; cycle("c2", 8'h70);
    call_en = 0; halt = 1; pc_cur = 8'h70; cycle("halt2", 8'h70);
    halt = 0; reset = 0; cycle("rst_halt", int'(RPC));
    reset = 1;
    check("rh_state", {6'b0, state}, 8'h00);
    check("rh_empty", {7'b0, stk_empty}, 8'h01);
    check("rh_err", {7'b0, err}, 8'h00);
    ret_en = 1; cycle("underflow", 8'h00);
    check("udf_state", {6'b0, state}, 8'h02);
    check("udf_err", {7'b0, err}, 8'h01);

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 39) != 0);
      stall    = ($urandom_range(0, 9) == 0);
      halt     = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      br_en    = ($urandom_range(0, 2) == 0);
      br_cond  = 1'($urandom);
      br_off   = 8'($urandom);
      jmp_en   = ($urandom_range(0, 4) == 0);
      call_en  = ($urandom_range(0, 3) == 0);
      ret_en   = ($urandom_range(0, 4) == 0);
      jmp_addr = 8'($urandom);
      pc_cur   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : m_last_pc;
      cycle("rand", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
